// File: rtl/cov_readout.sv
// Toggle-coverage collector: per-point saturating toggle counters, a registered
// covered summary, and a snapshot-and-stream dump port with valid/ready handshake.
module cov_readout #(
  parameter int unsigned NUM_POINTS = 16,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned IDX_WIDTH = ($clog2(NUM_POINTS) > 1) ? $clog2(NUM_POINTS) : 1,
  localparam int unsigned SUM_WIDTH = $clog2(NUM_POINTS + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cov_en,
  input  logic [NUM_POINTS-1:0] sig_in,
  input  logic                  clr_req,
  input  logic                  dump_req,
  output logic                  dump_busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_WIDTH-1:0]  out_idx,
  output logic [CNT_WIDTH-1:0]  out_count,
  output logic                  out_last,
  output logic [SUM_WIDTH-1:0]  covered_count,
  output logic                  covered_all
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_POINTS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state;
  logic [IDX_WIDTH-1:0]   ptr;
  logic [IDX_WIDTH-1:0]   ptr_nxt;
  logic [NUM_POINTS-1:0]  last_val;
  logic [NUM_POINTS-1:0]  toggle;
  logic [CNT_WIDTH-1:0]   cnt    [NUM_POINTS];
  logic [CNT_WIDTH-1:0]   shadow [NUM_POINTS];
  logic [SUM_WIDTH-1:0]   cov_sum;

  // Toggle detection against the last value seen while enabled
  always_comb begin
    toggle  = sig_in ^ last_val;
    ptr_nxt = IDX_WIDTH'(ptr + 1'b1);
  end

  // Live counters: clear wins over increment, saturate at all-ones
  always_ff @(posedge clock) begin
    if (reset) begin
      last_val <= '0;
      for (int i = 0; i < NUM_POINTS; i++) cnt[i] <= '0;
    end else begin
      if (cov_en) last_val <= sig_in;
      for (int i = 0; i < NUM_POINTS; i++) begin
        if (clr_req)
          cnt[i] <= '0;
        else if (cov_en && toggle[i] && (cnt[i] != CNT_MAX))
          cnt[i] <= CNT_WIDTH'(cnt[i] + 1'b1);
      end
    end
  end

  // Number of points whose live counter is nonzero
  always_comb begin
    cov_sum = '0;
    for (int i = 0; i < NUM_POINTS; i++)
      cov_sum = SUM_WIDTH'(cov_sum + SUM_WIDTH'(cnt[i] != '0));
  end

  // Registered coverage summary
  always_ff @(posedge clock) begin
    if (reset) begin
      covered_count <= '0;
      covered_all   <= 1'b0;
    end else begin
      covered_count <= cov_sum;
      covered_all   <= (cov_sum == SUM_WIDTH'(NUM_POINTS));
    end
  end

  // Dump FSM: snapshot counters, then stream one record per accepted handshake
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      dump_busy <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
      for (int i = 0; i < NUM_POINTS; i++) shadow[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dump_req) begin
            shadow    <= cnt;
            ptr       <= '0;
            state     <= SEND;
            dump_busy <= 1'b1;
            out_valid <= 1'b1;
            out_idx   <= '0;
            out_count <= cnt[0];
            out_last  <= 1'b0;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (ptr == LAST_IDX) begin
              state     <= IDLE;
              ptr       <= '0;
              dump_busy <= 1'b0;
              out_valid <= 1'b0;
              out_idx   <= '0;
              out_count <= '0;
              out_last  <= 1'b0;
            end else begin
              ptr       <= ptr_nxt;
              out_idx   <= ptr_nxt;
              out_count <= shadow[ptr_nxt];
              out_last  <= (ptr_nxt == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cov_readout.sv
// Bench for cov_readout with NUM_POINTS=4, CNT_WIDTH=4: a record-queue model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_cov_readout;

  localparam int NP   = 4;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          clock;
  logic          reset;
  logic          cov_en;
  logic [NP-1:0] sig_in;
  logic          clr_req;
  logic          dump_req;
  logic          dump_busy;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_idx;
  logic [CW-1:0] out_count;
  logic          out_last;
  logic [2:0]    covered_count;
  logic          covered_all;

  cov_readout #(.NUM_POINTS(NP), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .cov_en(cov_en), .sig_in(sig_in),
    .clr_req(clr_req), .dump_req(dump_req), .dump_busy(dump_busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_count(out_count), .out_last(out_last),
    .covered_count(covered_count), .covered_all(covered_all)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;
  bit armed  = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: counters as integers, a dump as a queue of records
  typedef struct {int idx; int cnt; bit last;} rec_t;
  rec_t q[$];
  int   m_cnt [NP];
  bit   m_last[NP];
  int   m_cov = 0;
  int   nz;
  bit   was_empty;
  bit   tog;

  initial forever begin
    @(posedge clock);
    if (reset) begin
      q.delete();
      for (int i = 0; i < NP; i++) begin m_cnt[i] = 0; m_last[i] = 0; end
      m_cov = 0;
    end else begin
      nz = 0;
      for (int i = 0; i < NP; i++) if (m_cnt[i] > 0) nz++;
      was_empty = (q.size() == 0);
      if (!was_empty && out_ready) void'(q.pop_front());
      if (was_empty && dump_req)
        for (int i = 0; i < NP; i++) q.push_back('{i, m_cnt[i], i == NP - 1});
      for (int i = 0; i < NP; i++) begin
        tog = 0;
        if (cov_en) begin
          tog = (sig_in[i] != m_last[i]);
          m_last[i] = sig_in[i];
        end
        if (clr_req) m_cnt[i] = 0;
        else if (tog && m_cnt[i] < MAXC) m_cnt[i] = m_cnt[i] + 1;
      end
      m_cov = nz;
    end
  end

  // Every-cycle comparison against the model
  initial forever begin
    @(negedge clock);
    if (armed) begin
      chk("out_valid", out_valid, q.size() > 0);
      chk("dump_busy", dump_busy, q.size() > 0);
      chk("out_idx",   out_idx,   q.size() > 0 ? q[0].idx : 0);
      chk("out_count", out_count, q.size() > 0 ? q[0].cnt : 0);
      chk("out_last",  out_last,  q.size() > 0 ? int'(q[0].last) : 0);
      chk("covered_count", covered_count, m_cov);
      chk("covered_all",   covered_all,   m_cov == NP);
    end
  end

  int got[NP];
  int nrec, nlast, last_idx, dump_cycles;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; cov_en = 0; sig_in = '0; clr_req = 0; dump_req = 0; out_ready = 0;
    step();
    reset = 0;
  endtask

  // Request a dump with out_ready held high and collect the records
  task automatic run_dump();
    nrec = 0; nlast = 0; last_idx = -1; dump_cycles = 0;
    for (int i = 0; i < NP; i++) got[i] = -1;
    dump_req = 1; out_ready = 1;
    step();
    dump_req = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (out_valid) begin
        got[out_idx] = out_count;
        nrec++;
        if (out_last) begin nlast++; last_idx = out_idx; end
      end
      step();
      dump_cycles++;
      if (nrec == NP) break;
    end
    chk("dump_records", nrec, NP);
  endtask

  initial begin
    reset = 1; cov_en = 0; sig_in = '0; clr_req = 0; dump_req = 0; out_ready = 0;
    step();
    armed = 1;
    step();
    reset = 0;
    chk("rst_covered_count", covered_count, 0);
    chk("rst_out_valid", out_valid, 0);

    // Saturation on point 0
    cov_en = 1;
    for (int k = 0; k < 20; k++) begin sig_in[0] = ~sig_in[0]; step(); end
    step(); step();
    chk("sat_covered_count", covered_count, 1);
    chk("sat_covered_all", covered_all, 0);
    run_dump();
    chk("sat_cnt0", got[0], 15);
    chk("sat_cnt1", got[1], 0);

    // Disabled toggles are ignored; first enabled cycle sees sig_in != last
    do_reset();
    for (int k = 0; k < 5; k++) begin sig_in = ~sig_in; step(); end
    chk("dis_covered_count", covered_count, 0);
    cov_en = 1;
    step(); step();
    chk("en_covered_count", covered_count, 4);
    chk("en_covered_all", covered_all, 1);
    run_dump();
    for (int i = 0; i < NP; i++) chk("en_cnt", got[i], 1);

    // Counts {3,0,7,1} streamed on consecutive cycles
    do_reset();
    cov_en = 1;
    for (int k = 0; k < 7; k++) begin
      sig_in[2] = ~sig_in[2];
      if (k < 3) sig_in[0] = ~sig_in[0];
      if (k == 0) sig_in[3] = ~sig_in[3];
      step();
    end
    step();
    run_dump();
    chk("d_cnt0", got[0], 3);
    chk("d_cnt1", got[1], 0);
    chk("d_cnt2", got[2], 7);
    chk("d_cnt3", got[3], 1);
    chk("d_cycles", dump_cycles, NP);
    chk("d_nlast", nlast, 1);
    chk("d_last_idx", last_idx, 3);
    chk("d_busy_after", dump_busy, 0);

    // Stall on idx 1 while point 1 keeps toggling; repeated dump_req ignored
    dump_req = 1; out_ready = 1;
    step();
    step();
    out_ready = 0;
    chk("stall_cov_before", covered_count, 3);
    for (int k = 0; k < 3; k++) begin
      sig_in[1] = ~sig_in[1];
      step();
      chk("stall_idx", out_idx, 1);
      chk("stall_count", out_count, 0);
    end
    chk("stall_cov_after", covered_count, 4);
    dump_req = 0; out_ready = 1;
    for (int k = 0; k < 10 && out_valid; k++) step();
    chk("stall_drained", out_valid, 0);

    // Clear with a coincident toggle on point 2
    clr_req = 1; sig_in[2] = ~sig_in[2];
    step();
    clr_req = 0;
    chk("clr_cov_lag", covered_count, 4);
    step();
    chk("clr_cov", covered_count, 0);
    run_dump();
    for (int i = 0; i < NP; i++) chk("clr_cnt", got[i], 0);

    // Reset in the middle of a dump
    for (int k = 0; k < 2; k++) begin sig_in = ~sig_in; step(); end
    step();
    dump_req = 1; out_ready = 1;
    step();
    dump_req = 0;
    step(); step();
    chk("mid_idx", out_idx, 2);
    reset = 1; cov_en = 0;
    step();
    reset = 0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", dump_busy, 0);
    step();
    chk("abort_cov", covered_count, 0);
    run_dump();
    for (int i = 0; i < NP; i++) chk("abort_cnt", got[i], 0);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
